// File: rtl/sdram_pattern_tester.sv
// LFSR pattern write/read-back tester driving the BigSDRAM user command port.
// Reports the result on status outputs and a single LED.
module sdram_pattern_tester #(
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned TEST_WORDS = 256,
    parameter logic [31:0] SEED       = 32'hA5A50001,
    parameter int unsigned BLINK_DIV  = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  leds
);
    localparam int unsigned      IDX_W    = $clog2(TEST_WORDS + 1);
    localparam int unsigned      LED_W    = BLINK_DIV + 1;
    localparam int unsigned      REPS     = (DATA_WIDTH + 31) / 32;
    localparam logic [31:0]      POLY     = 32'h80200003;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic [15:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [LED_W-1:0]        led_cnt_q, led_cnt_d;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [DATA_WIDTH-1:0]   lfsr_word;

    assign accept    = cmd_valid_q && cmd_ready;
    assign word_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
    assign lfsr_word = DATA_WIDTH'({REPS{lfsr_q}});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        cmd_valid_d = cmd_valid_q;
        led_cnt_d   = led_cnt_q + LED_W'(1);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    idx_d       = '0;
                    lfsr_d      = SEED;
                    err_d       = '0;
                    first_err_d = '0;
                    cmd_valid_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_READ_REQ;
                        idx_d   = '0;
                        lfsr_d  = SEED;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                end
            end
            S_READ_REQ: begin
                if (accept) begin
                    state_d     = S_READ_WAIT;
                    cmd_valid_d = 1'b0;
                end
            end
            S_READ_WAIT: begin
                if (rd_valid) begin
                    // err_q never returns to zero within a run, so zero marks the first miss
                    if (rd_data != lfsr_word) begin
                        if (err_q == '0) first_err_d = word_addr;
                        if (err_q != '1) err_d = err_q + 16'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_READ_REQ;
                        idx_d       = idx_q + IDX_W'(1);
                        lfsr_d      = lfsr_step(lfsr_q);
                        cmd_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lfsr_q      <= SEED;
            err_q       <= '0;
            first_err_q <= '0;
            cmd_valid_q <= 1'b0;
            led_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            cmd_valid_q <= cmd_valid_d;
            led_cnt_q   <= led_cnt_d;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_write      = cmd_valid_q && (state_q == S_WRITE);
    assign cmd_addr       = cmd_valid_q ? word_addr : '0;
    assign cmd_wdata      = cmd_write ? lfsr_word : '0;
    assign busy           = (state_q == S_WRITE) || (state_q == S_READ_REQ) ||
                            (state_q == S_READ_WAIT);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == '0);
    assign error_count    = err_q;
    assign first_err_addr = first_err_q;

    always_comb begin
        unique case (state_q)
            S_IDLE:  leds = 1'b0;
            S_DONE:  leds = (err_q == '0) ? 1'b1 : led_cnt_q[BLINK_DIV-3];
            default: leds = led_cnt_q[BLINK_DIV];
        endcase
    end
endmodule
